store_sequence_checker: RTL and testbench

// - Synthesisable, self-checking monitor of the data-memory store port (memwrite/dataadr/writedata) of the pipelined MIPS core.
// - Holds a loadable table of up to DEPTH expected stores (address, size, data) and checks the actual stores against it, in order.
// - Reports pass/fail, the failing index and the failure cause.
// - Generalises the single-store sw/sh bench check to multi-store sequences with sb/sh/sw sizes; usable in sim or on FPGA.

---
 rtl/store_sequence_checker.sv | 172 +++++++++++++++++
 tb/tb_store_sequence_checker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_sequence_checker.sv
// store_sequence_checker: checks MIPS data-memory stores against a loadable
// table of expected (address, size, data) entries, in order.
// Ports: clk, reset (sync, active-high), memwrite/dataadr/writedata (store
// port), exp_wr/exp_idx/exp_adr/exp_size/exp_data (table load), exp_count and
// start (begin a run), busy/pass/fail/fail_idx/fail_cause (verdict).
// Optional watchdog: define STORE_CHK_TIMEOUT_EN to fail a run that takes
// TIMEOUT cycles.
module store_sequence_checker #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024,
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  input  logic              exp_wr,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [ADDR_W-1:0] exp_adr,
  input  logic [1:0]        exp_size,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [IDX_W:0]    exp_count,
  input  logic              start,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [2:0]        fail_cause
);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_PASS, S_FAIL
  } state_t;

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  logic [ADDR_W-1:0] tbl_adr  [DEPTH];
  logic [1:0]        tbl_size [DEPTH];
  logic [DATA_W-1:0] tbl_data [DEPTH];

  state_t         state, state_d;
  logic [IDX_W-1:0] ptr, ptr_d;
  logic [IDX_W:0]   cnt, cnt_d;
  logic [IDX_W-1:0] idx_d;
  logic [2:0]       cause_d;

  logic [ADDR_W-1:0] e_adr;
  logic [1:0]        e_size;
  logic [DATA_W-1:0] e_data;
  logic [DATA_W-1:0] mask;
  logic              is_store;
  logic              last;
  logic              bad_adr;
  logic              bad_size;
  logic              bad_data;

  assign e_adr  = tbl_adr[ptr];
  assign e_size = tbl_size[ptr];
  assign e_data = tbl_data[ptr];

  always_comb begin
    mask = '1;
    case (e_size)
      2'b10:   mask = DATA_W'(16'hFFFF);
      2'b11:   mask = DATA_W'(8'hFF);
      default: mask = '1;
    endcase
  end

  assign is_store = memwrite != 2'b00;
  assign last     = {1'b0, ptr} == cnt - 1'b1;
  assign bad_adr  = dataadr != e_adr;
  assign bad_size = memwrite != e_size;
  assign bad_data = ((writedata ^ e_data) & mask) != '0;

`ifdef STORE_CHK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          t_hit;

  assign t_hit = tcnt == TW'(TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (reset)
      tcnt <= '0;
    else if (state == S_IDLE && start)
      tcnt <= '0;
    else if (state == S_RUN)
      tcnt <= tcnt + 1'b1;
  end
`endif

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    idx_d   = fail_idx;
    cause_d = fail_cause;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          ptr_d   = '0;
          cnt_d   = (exp_count > DEPTH_C) ? DEPTH_C : exp_count;
          state_d = (exp_count == '0) ? S_PASS : S_RUN;
        end
      end
      S_RUN: begin
        if (is_store) begin
          if (bad_adr || bad_size || bad_data) begin
            state_d = S_FAIL;
            idx_d   = ptr;
            if (bad_adr)
              cause_d = 3'b001;
            else if (bad_size)
              cause_d = 3'b010;
            else
              cause_d = 3'b011;
          end else if (last) begin
            state_d = S_PASS;
          end else begin
            ptr_d = ptr + 1'b1;
          end
        end
`ifdef STORE_CHK_TIMEOUT_EN
        // a store that settles the run this cycle beats the watchdog
        if (t_hit && state_d == S_RUN) begin
          state_d = S_FAIL;
          idx_d   = ptr;
          cause_d = 3'b100;
        end
`endif
      end
      S_PASS: state_d = S_PASS;
      S_FAIL: state_d = S_FAIL;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      fail_idx   <= '0;
      fail_cause <= 3'b000;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      cnt        <= cnt_d;
      fail_idx   <= idx_d;
      fail_cause <= cause_d;
    end
  end

  // table survives reset so a run can be repeated without reloading
  always_ff @(posedge clk) begin
    if (!reset && state == S_IDLE && exp_wr
        && ({1'b0, exp_idx} < DEPTH_C)) begin
      tbl_adr[exp_idx]  <= exp_adr;
      tbl_size[exp_idx] <= exp_size;
      tbl_data[exp_idx] <= exp_data;
    end
  end

  assign busy = state == S_RUN;
  assign pass = state == S_PASS;
  assign fail = state == S_FAIL;

endmodule

// File: tb/tb_store_sequence_checker.sv
// tb_store_sequence_checker: directed stimulus for store_sequence_checker
// with a per-cycle reference model plus literal spot checks.
module tb_store_sequence_checker;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DEPTH = 8;
  localparam int TMO = 16;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    memwrite;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;
  logic          exp_wr;
  logic [IW-1:0] exp_idx;
  logic [AW-1:0] exp_adr;
  logic [1:0]    exp_size;
  logic [DW-1:0] exp_data;
  logic [IW:0]   exp_count;
  logic          start;
  logic          busy, pass, fail;
  logic [IW-1:0] fail_idx;
  logic [2:0]    fail_cause;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  store_sequence_checker #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata),
    .exp_wr(exp_wr), .exp_idx(exp_idx), .exp_adr(exp_adr),
    .exp_size(exp_size), .exp_data(exp_data),
    .exp_count(exp_count), .start(start),
    .busy(busy), .pass(pass), .fail(fail),
    .fail_idx(fail_idx), .fail_cause(fail_cause)
  );

  always #5 clk = ~clk;

  // reference model: phase 0 idle, 1 running, 2 passed, 3 failed
  longint t_adr [DEPTH];
  int     t_size[DEPTH];
  longint t_data[DEPTH];
  int m_phase = 0;
  int m_pos = 0;
  int m_len = 0;
  int m_cyc = 0;
  int m_idx = 0;
  int m_cause = 0;

  function automatic int keep_bytes(int sz);
    if (sz == 1) return 4;
    if (sz == 2) return 2;
    return 1;
  endfunction

  function automatic int why_bad(int k);
    longint m;
    if (longint'(dataadr) != t_adr[k]) return 1;
    if (int'(memwrite) != t_size[k]) return 2;
    m = longint'(1) << (8 * keep_bytes(t_size[k]));
    if (longint'(writedata) % m != t_data[k] % m) return 3;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= 0; m_pos <= 0;
      m_idx <= 0; m_cause <= 0;
    end else if (m_phase == 0) begin
      if (exp_wr) begin
        t_adr[exp_idx]  <= longint'(exp_adr);
        t_size[exp_idx] <= int'(exp_size);
        t_data[exp_idx] <= longint'(exp_data);
      end
      if (start) begin
        m_len <= (int'(exp_count) > DEPTH) ? DEPTH : int'(exp_count);
        m_pos <= 0;
        m_cyc <= 0;
        m_phase <= (exp_count == 0) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      m_cyc <= m_cyc + 1;
      if (memwrite != 0 && why_bad(m_pos) != 0) begin
        m_phase <= 3; m_idx <= m_pos;
        m_cause <= why_bad(m_pos);
      end else if (memwrite != 0 && m_pos + 1 == m_len) begin
        m_phase <= 2;
      end else begin
        if (memwrite != 0) m_pos <= m_pos + 1;
`ifdef STORE_CHK_TIMEOUT_EN
        if (m_cyc + 1 == TMO) begin
          m_phase <= 3; m_idx <= m_pos; m_cause <= 4;
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (busy !== (m_phase == 1) || pass !== (m_phase == 2)
          || fail !== (m_phase == 3)
          || int'(fail_idx) != m_idx
          || int'(fail_cause) != m_cause) begin
        errors++;
        $display("FAIL model t=%0t dut b%0b p%0b f%0b i%0d c%0d want ph%0d i%0d c%0d",
                 $time, busy, pass, fail, fail_idx, fail_cause,
                 m_phase, m_idx, m_cause);
      end
    end
  end

  task automatic chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(int i, int a, int sz, logic [31:0] d);
    exp_wr = 1'b1; exp_idx = IW'(i);
    exp_adr = AW'(a); exp_size = 2'(sz); exp_data = d;
    tick();
    exp_wr = 1'b0;
  endtask

  task automatic go(int n);
    start = 1'b1; exp_count = (IW+1)'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic st(int sz, int a, logic [31:0] d);
    memwrite = 2'(sz); dataadr = AW'(a); writedata = d;
    tick();
    memwrite = 2'b00;
  endtask

  task automatic seq3();
    st(1, 84, 32'h12345678); tick();
    st(3, 88, 32'h000000AB); tick();
    st(2, 90, 32'h0000BEEF);
  endtask

  initial begin
    reset = 1'b1; memwrite = 0; dataadr = 0; writedata = 0;
    exp_wr = 0; exp_idx = 0; exp_adr = 0; exp_size = 0;
    exp_data = 0; exp_count = 0; start = 0;
    tick();
    chk_en = 1;
    tick();
    reset = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_cause", int'(fail_cause), 0);

    load(0, 80, 2, 32'h0000FFFF);
    go(1);
    st(2, 80, 32'hFFFFFFFF);
    chk("sh_pass", int'(pass), 1);
    chk("sh_busy", int'(busy), 0);

    do_reset();
    load(0, 84, 1, 32'h12345678);
    load(1, 88, 3, 32'h000000AB);
    load(2, 90, 2, 32'h0000BEEF);
    go(3);
    st(1, 84, 32'h12345678); tick();
    st(3, 88, 32'h000000AB); tick();
    chk("seq_early", int'(pass), 0);
    st(2, 90, 32'h0000BEEF);
    chk("seq_pass", int'(pass), 1);
    st(1, 4, 32'h0);
    chk("after_pass", int'(pass), 1);
    chk("after_fail", int'(fail), 0);

    do_reset(); go(3);
    st(1, 84, 32'h12345678); st(3, 92, 32'h000000AB);
    chk("adr_fail", int'(fail), 1);
    chk("adr_idx", int'(fail_idx), 1);
    chk("adr_cause", int'(fail_cause), 1);

    do_reset(); go(3);
    st(1, 84, 32'h12345678); st(1, 88, 32'h000000AB);
    chk("size_cause", int'(fail_cause), 2);

    do_reset(); go(3);
    st(1, 84, 32'h12345678); st(3, 88, 32'h123456AC);
    chk("data_cause", int'(fail_cause), 3);

    do_reset(); go(0);
    chk("cnt0_pass", int'(pass), 1);

    do_reset();
    start = 1'b1; exp_count = 3;
    memwrite = 1; dataadr = 84; writedata = 32'h12345678;
    tick();
    start = 1'b0; memwrite = 0;
    chk("startst_busy", int'(busy), 1);
    seq3();
    chk("startst_pass", int'(pass), 1);

    do_reset(); go(3);
    st(1, 84, 32'h12345678);
    do_reset();
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pass", int'(pass), 0);
    go(3); seq3();
    chk("midrst_pass2", int'(pass), 1);

    do_reset();
    for (int i = 3; i < DEPTH; i++)
      load(i, 100 + 4 * i, 1, 32'(i));
    go(15);
    seq3();
    for (int i = 3; i < DEPTH; i++) begin
      chk("sat_notyet", int'(pass), 0);
      st(1, 100 + 4 * i, 32'(i));
    end
    chk("sat_pass", int'(pass), 1);

    do_reset(); go(1);
    for (int i = 0; i < TMO - 1; i++) tick();
    chk("tmo_early", int'(fail), 0);
    tick();
`ifdef STORE_CHK_TIMEOUT_EN
    chk("tmo_fail", int'(fail), 1);
    chk("tmo_cause", int'(fail_cause), 4);
`else
    for (int i = 0; i < 24; i++) tick();
    chk("notmo_busy", int'(busy), 1);
`endif
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
